pipe_mdu: RTL and testbench
===========================

PIPE_MDU -- requirements
Module: pipe_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal values are even and 8..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request; sampled only in IDLE.
REQ-006 Port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others NOP.
REQ-007 Port src_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-008 Port src_b  input  WIDTH  multiplier / divisor.
REQ-009 Port flush  input  1  cancel in-flight operation (branch/exception squash).
REQ-010 Port busy  output  1  high while state is CALC or FIX; pipeline stall request.
REQ-011 Port done  output  1  registered one-cycle pulse after HI/LO update from MULT/DIV.
REQ-012 Port hi  output  WIDTH  HI register.
REQ-013 Port lo  output  WIDTH  LO register.

Function
REQ-014 FSM states IDLE, CALC, FIX; busy derived from the state only.
REQ-015 IDLE, start=1, flush=0, op MULT/MULTU/DIV/DIVU: capture operand magnitudes (signed ops: absolute values) and result signs, load counter with WIDTH, enter CALC.
REQ-016 IDLE, start=1, flush=0, op MTHI/MTLO: write src_a into hi/lo at that edge, stay IDLE, no busy, no done.
REQ-017 IDLE, start=1, op NOP: no state change.
REQ-018 CALC: one radix-2 step per cycle (shift-add multiply, restoring divide), counter decrements; at counter 1 enter FIX.
REQ-019 FIX: apply sign correction, write hi/lo, assert done for the following cycle, return to IDLE.
REQ-020 Latency: accepting edge E0; hi/lo written and done registered at edge E(WIDTH+1); busy low and done high in the same cycle after that edge.
REQ-021 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, two's-complement for MULT.
REQ-022 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign.
REQ-023 Divide by zero: hi = src_a, lo = all ones, normal latency, done pulsed.
REQ-024 DIV, most-negative / -1: lo = most-negative value, hi = 0, no exception.
REQ-025 start while busy: ignored, no queuing.
REQ-026 flush in CALC or FIX: return to IDLE at next edge; hi/lo unchanged; no done.
REQ-027 flush with start in IDLE: flush wins; nothing accepted; hi/lo unchanged.
REQ-028 Operands captured at E0; later src_a/src_b changes have no effect.

Reset
REQ-029 reset low asynchronously forces IDLE, busy=0, done=0, hi=0, lo=0, counter=0, datapath registers 0.
REQ-030 reset mid-operation discards the operation; no done after release.
REQ-031 First acceptance possible at the first rising edge with reset high.

Structure
REQ-032 Shared package holds the op encoding constants, FSM state encoding and default WIDTH.
REQ-033 One sub-module, mdu_step, combinationally computes one shift-add / restore-subtract iteration; FSM, counter and HI/LO stay in pipe_mdu.

Verification (WIDTH=32)
REQ-034 MULT src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle, busy high 33 cycles.
REQ-035 DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIV src_a=0x80000000, src_b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> hi=5, lo=0xFFFFFFFF.
REQ-037 MULTU started, flush at cycle 10 -> IDLE next cycle, hi/lo keep prior values, no done; new start accepted the following cycle.
REQ-038 MTLO 0x12345678 while IDLE -> lo updates at that edge, busy stays 0; start during busy ignored, result matches the first op.
REQ-039 reset low at CALC cycle 5 -> busy=0, hi=lo=0 immediately, no done after release.

Source files
------------

// File: rtl/pipe_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encoding, the FSM state encoding and the default operand width.
package pipe_mdu_pkg;

    localparam int unsigned DefaultWidth = 32;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10
    } state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   is_div_i  1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i/o   upper half: partial product (mult) or partial remainder (div)
//   mq_i/o    lower half: multiplier bits (mult) or dividend/quotient bits (div)
//   m_i       multiplicand (mult) or divisor (div) magnitude
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mq_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;

    always_comb begin
        sum    = {1'b0, acc_i} + ({1'b0, m_i} & {(WIDTH + 1){mq_i[0]}});
        rem_sh = {acc_i, mq_i[WIDTH-1]};
        if (is_div_i) begin
            if (rem_sh >= {1'b0, m_i}) begin
                // Difference is below the divisor, so the low WIDTH bits are exact.
                acc_o = rem_sh[WIDTH-1:0] - m_i;
                mq_o  = {mq_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = rem_sh[WIDTH-1:0];
                mq_o  = {mq_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift {carry, acc, mq} right by one after the conditional add.
            acc_o = sum[WIDTH:1];
            mq_o  = {sum[0], mq_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/pipe_mdu.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start, op       request and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO), sampled in idle
//   src_a, src_b    operands
//   flush           cancel the in-flight operation
//   busy            high while calculating or fixing up signs
//   done            one-cycle pulse after HI/LO update from a multiply/divide
//   hi, lo          HI and LO registers
module pipe_mdu
    import pipe_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               div_q, div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept;
    logic               in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   step_acc, step_mq;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    // Arithmetic ops are 0xx; signed variants have op[0] clear.
    assign accept   = (state_q == StIdle) && start && !flush && !op[2];
    assign in_neg_a = !op[0] && src_a[WIDTH-1];
    assign in_neg_b = !op[0] && src_b[WIDTH-1];
    assign mag_a    = in_neg_a ? -src_a : src_a;
    assign mag_b    = in_neg_b ? -src_b : src_b;

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (div_q),
        .acc_i    (acc_q),
        .mq_i     (mq_q),
        .m_i      (m_q),
        .acc_o    (step_acc),
        .mq_o     (step_mq)
    );

    // FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StCalc;
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Datapath and HI/LO next state.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        m_d     = m_q;
        div_d   = div_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        prod = {acc_q, mq_q};
        if (neg_a_q ^ neg_b_q) prod = -prod;
        quot = (neg_a_q ^ neg_b_q) ? -mq_q : mq_q;
        rem  = neg_a_q ? -acc_q : acc_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = CNT_W'(WIDTH);
                    acc_d   = '0;
                    div_d   = op[1];
                    mq_d    = op[1] ? mag_a : mag_b;
                    m_d     = op[1] ? mag_b : mag_a;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                end else if (start && !flush && op == OpMthi) begin
                    hi_d = src_a;
                end else if (start && !flush && op == OpMtlo) begin
                    lo_d = src_a;
                end
            end
            StCalc: begin
                if (!flush) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    acc_d = step_acc;
                    mq_d  = step_mq;
                end
            end
            StFix: begin
                if (!flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        // With a zero divisor the remainder path shifts the whole dividend
                        // magnitude in, so the signed remainder already equals src_a.
                        hi_d = rem;
                        lo_d = (m_q == '0) ? '1 : quot;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            m_q     <= '0;
            div_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            m_q     <= m_d;
            div_q   <= div_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_pipe_mdu.sv
module tb_pipe_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] src_a = 32'h0;
    logic [31:0] src_b = 32'h0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always #5 clk = ~clk;

    pipe_mdu #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'b000: begin p = sa * sb; {m_hi, m_lo} = p; end
            3'b001: begin up = {32'h0, a} * {32'h0, b}; {m_hi, m_lo} = up; end
            3'b010: begin
                if (b == 32'h0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            3'b011: begin
                if (b == 32'h0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            3'b100: m_hi = a;
            3'b101: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at a negedge. Optionally pokes start mid-operation.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        int cycles;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; src_a = $urandom; src_b = $urandom;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (inject && cycles == 5) begin start = 1'b1; op = 3'($urandom_range(0, 3)); end
            if (cycles == 6) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        model(o, a, b);
        check("busy_cycles", 64'(cycles), 64'd33);
        check("done_pulse", 64'(done), 64'd1);
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        @(negedge clk);
        check("done_clears", 64'(done), 64'd0);
    endtask

    // Single-cycle ops (MTHI/MTLO/NOP), optionally with flush asserted.
    task automatic mt(input logic [2:0] o, input logic [31:0] a, input bit fl);
        start = 1'b1; op = o; src_a = a; flush = fl;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        if (!fl) model(o, a, 32'h0);
        check("mt_busy", 64'(busy), 64'd0);
        check("mt_done", 64'(done), 64'd0);
        check("mt_hi", 64'(hi), 64'(m_hi));
        check("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        bit          saw;
        logic [2:0]  o;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        run_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        run_op(3'b011, 32'd100, 32'd7, 1'b0);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b011, 32'd5, 32'd0, 1'b0);
        run_op(3'b010, 32'hFFFF_FFF3, 32'd0, 1'b0);
        mt(3'b101, 32'h1234_5678, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // flush+start in idle: nothing accepted
        mt(3'b101, 32'hDEAD_BEEF, 1'b1);
        mt(3'b000, 32'h0000_0005, 1'b1);

        // flush mid-CALC
        start = 1'b1; op = 3'b001; src_a = 32'h0001_0001; src_b = 32'h0003_0003;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(hi), 64'(m_hi));
        check("flush_lo", 64'(lo), 64'(m_lo));
        run_op(3'b000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
            run_op(o, a, b, bit'($urandom_range(0, 1)));
            mt(3'($urandom_range(4, 7)), $urandom, 1'b0);
        end

        // reset mid-operation
        mt(3'b100, 32'hA5A5_0001, 1'b0);
        start = 1'b1; op = 3'b001; src_a = $urandom | 32'h1; src_b = $urandom | 32'h1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        m_hi = 32'h0; m_lo = 32'h0;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'(m_hi));
        check("arst_lo", 64'(lo), 64'(m_lo));
        @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        check("no_done_after_rst", 64'(saw), 64'd0);
        run_op(3'b010, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
